// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake bundle for the sequential divider.
//   start       : request, honoured when the divider is idle or finishing
//   a, b        : dividend / divisor, captured on the accepted start edge
//   busy        : divider is iterating
//   done        : one-cycle completion pulse, q/r/div_by_zero valid
//   q, r        : quotient / remainder, held until the next completion
//   div_by_zero : last completed operation had a zero divisor
// master = requester (ALU control), slave = divider.
interface seq_divider_if #(
  parameter int SIZE = 8
);
  logic            start;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] q;
  logic [SIZE-1:0] r;
  logic            div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, q, r, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, r, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: iterative restoring unsigned divider, one quotient bit per clock.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, overrides any operation in flight
//   bus   : seq_divider_if slave (start/a/b in, busy/done/q/r/div_by_zero out)
// A normal divide takes SIZE iterations; a zero divisor completes immediately
// with q = all ones, r = dividend and div_by_zero set.
module seq_divider #(
  parameter int SIZE = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  // Partial remainder is always < b after each step, so SIZE bits hold it;
  // only the shifted trial value needs the extra bit.
  logic [SIZE-1:0] p_reg, p_next;
  // Dividend shifts out of the MSB while quotient bits shift in at the LSB.
  logic [SIZE-1:0] dq_reg, dq_next;
  logic [SIZE-1:0] b_reg, b_next;
  logic [SIZE-1:0] q_reg, q_next;
  logic [SIZE-1:0] r_reg, r_next;
  logic            dbz_reg, dbz_next;

  logic [SIZE:0]   p_shift;
  logic [SIZE:0]   diff;
  logic            ge;
  logic [SIZE-1:0] p_iter;
  logic [SIZE-1:0] dq_iter;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      p_reg     <= '0;
      dq_reg    <= '0;
      b_reg     <= '0;
      q_reg     <= '0;
      r_reg     <= '0;
      dbz_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      p_reg     <= p_next;
      dq_reg    <= dq_next;
      b_reg     <= b_next;
      q_reg     <= q_next;
      r_reg     <= r_next;
      dbz_reg   <= dbz_next;
    end
  end

  // One restoring step. p_shift < 2*b, so a non-negative difference is < b
  // and fits SIZE bits; a negative one always sets the top bit.
  always_comb begin
    p_shift = {p_reg, dq_reg[SIZE-1]};
    diff    = p_shift - {1'b0, b_reg};
    ge      = ~diff[SIZE];
    p_iter  = ge ? diff[SIZE-1:0] : p_shift[SIZE-1:0];
    dq_iter = {dq_reg[SIZE-2:0], ge};
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    p_next     = p_reg;
    dq_next    = dq_reg;
    b_next     = b_reg;
    q_next     = q_reg;
    r_next     = r_reg;
    dbz_next   = dbz_reg;

    case (state_reg)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          b_next   = bus.b;
          p_next   = '0;
          cnt_next = '0;
          if (bus.b == '0) begin
            state_next = S_DONE;
            dq_next    = '0;
            q_next     = '1;
            r_next     = bus.a;
            dbz_next   = 1'b1;
          end else begin
            state_next = S_RUN;
            dq_next    = bus.a;
          end
        end else if (state_reg == S_DONE) begin
          state_next = S_IDLE;
        end
      end

      S_RUN: begin
        p_next   = p_iter;
        dq_next  = dq_iter;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CW'(SIZE - 1)) begin
          state_next = S_DONE;
          q_next     = dq_iter;
          r_next     = p_iter;
          dbz_next   = 1'b0;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

  assign bus.busy        = (state_reg == S_RUN);
  assign bus.done        = (state_reg == S_DONE);
  assign bus.q           = q_reg;
  assign bus.r           = r_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vector table plus hand-written corner sequences
// (ignored start, back-to-back start, mid-operation reset) and a random sweep
// for seq_divider with SIZE = 8. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_seq_divider;

  localparam int SIZE = 8;

  typedef struct {
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic [SIZE-1:0] q;
    logic [SIZE-1:0] r;
    logic            dbz;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass = 0;
  int   n_total = 0;

  seq_divider_if #(.SIZE(SIZE)) bus ();

  seq_divider #(.SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Present one start request; returns at the falling edge after the
  // accepting edge with operands scrambled (they are don't-care afterwards).
  task automatic launch(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = SIZE'($urandom);
    bus.b     = SIZE'($urandom);
  endtask

  // Wait (bounded) for done. edges counts falling edges since the start
  // edge, beginning at edges_in; busy_n counts busy samples seen meanwhile.
  task automatic wait_done(input int edges_in, output int edges, output int busy_n);
    edges  = edges_in;
    busy_n = 0;
    while (!bus.done && edges < SIZE + 6) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int edges, busy_n;
    launch(v.a, v.b);
    wait_done(1, edges, busy_n);
    check("done_seen", int'(bus.done), 1);
    check("latency", edges, v.dbz ? 1 : SIZE + 1);
    check("busy_cycles", busy_n, v.dbz ? 0 : SIZE);
    check("q", int'(bus.q), int'(v.q));
    check("r", int'(bus.r), int'(v.r));
    check("div_by_zero", int'(bus.div_by_zero), int'(v.dbz));
    $display("op a=%0d b=%0d -> q=%0d r=%0d dbz=%0d latency=%0d",
             v.a, v.b, bus.q, bus.r, bus.div_by_zero, edges);
    @(negedge clk);
    check("done_pulse_ends", int'(bus.done), 0);
    check("q_held", int'(bus.q), int'(v.q));
  endtask

  initial begin
    vec_t vecs[11];
    int edges, busy_n, done_cnt;

    vecs[0]  = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,  dbz: 1'b0};
    vecs[1]  = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,  dbz: 1'b0};
    vecs[2]  = '{a: 8'd5,   b: 8'd9,   q: 8'd0,   r: 8'd5,  dbz: 1'b0};
    vecs[3]  = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,  dbz: 1'b0};
    vecs[4]  = '{a: 8'd37,  b: 8'd0,   q: 8'd255, r: 8'd37, dbz: 1'b1};
    vecs[5]  = '{a: 8'd9,   b: 8'd3,   q: 8'd3,   r: 8'd0,  dbz: 1'b0};
    vecs[6]  = '{a: 8'd1,   b: 8'd255, q: 8'd0,   r: 8'd1,  dbz: 1'b0};
    vecs[7]  = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,  dbz: 1'b0};
    vecs[8]  = '{a: 8'd128, b: 8'd2,   q: 8'd64,  r: 8'd0,  dbz: 1'b0};
    vecs[9]  = '{a: 8'd254, b: 8'd128, q: 8'd1,   r: 8'd126, dbz: 1'b0};
    vecs[10] = '{a: 8'd0,   b: 8'd0,   q: 8'd255, r: 8'd0,  dbz: 1'b1};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_q", int'(bus.q), 0);
    check("rst_r", int'(bus.r), 0);
    check("rst_dbz", int'(bus.div_by_zero), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Start pulse during RUN must be ignored.
    launch(8'd100, 8'd10);
    repeat (2) begin
      check("busy_before_ignored", int'(bus.busy), 1);
      @(negedge clk);
    end
    bus.start = 1'b1;
    bus.a     = 8'd1;
    bus.b     = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(4, edges, busy_n);
    check("ign_latency", edges, SIZE + 1);
    check("ign_q", int'(bus.q), 10);
    check("ign_r", int'(bus.r), 0);
    $display("op a=100 b=10 with ignored start -> q=%0d r=%0d latency=%0d",
             bus.q, bus.r, edges);

    // Back-to-back: new start accepted during the done cycle.
    launch(8'd250, 8'd3);
    wait_done(1, edges, busy_n);
    check("b2b_first_done", int'(bus.done), 1);
    check("b2b_first_q", int'(bus.q), 83);
    check("b2b_first_r", int'(bus.r), 1);
    $display("op a=250 b=3 -> q=%0d r=%0d", bus.q, bus.r);
    bus.start = 1'b1;
    bus.a     = 8'd17;
    bus.b     = 8'd4;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'd99;
    bus.b     = 8'd99;
    check("b2b_done_drops", int'(bus.done), 0);
    check("b2b_busy", int'(bus.busy), 1);
    check("b2b_q_held", int'(bus.q), 83);
    wait_done(1, edges, busy_n);
    check("b2b_second_latency", edges, SIZE + 1);
    check("b2b_second_q", int'(bus.q), 4);
    check("b2b_second_r", int'(bus.r), 1);
    $display("op a=17 b=4 back-to-back -> q=%0d r=%0d latency=%0d",
             bus.q, bus.r, edges);

    // Reset in the middle of an operation discards it.
    launch(8'd200, 8'd7);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_q", int'(bus.q), 0);
    check("midrst_r", int'(bus.r), 0);
    check("midrst_dbz", int'(bus.div_by_zero), 0);
    done_cnt = 0;
    repeat (SIZE + 3) begin
      if (bus.done || bus.busy) done_cnt++;
      @(negedge clk);
    end
    check("midrst_no_activity", done_cnt, 0);
    $display("reset mid-operation -> busy=%0d done=%0d q=%0d r=%0d",
             bus.busy, bus.done, bus.q, bus.r);
    run_vec('{a: 8'd9, b: 8'd2, q: 8'd4, r: 8'd1, dbz: 1'b0});

    // Random sweep with a nonzero divisor.
    for (int k = 0; k < 1000; k++) begin
      logic [SIZE-1:0] ra, rb;
      int qi, ri;
      ra = SIZE'($urandom_range(0, 255));
      rb = SIZE'($urandom_range(1, 255));
      launch(ra, rb);
      wait_done(1, edges, busy_n);
      qi = int'(bus.q);
      ri = int'(bus.r);
      check("rand_invariant",
            int'((qi * int'(rb) + ri == int'(ra)) && (ri < int'(rb)) && bus.done), 1);
      $display("rand op a=%0d b=%0d -> q=%0d r=%0d", ra, rb, qi, ri);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
